seq_loop_monitor: RTL and testbench

Cycle-accurate consumer of the sequential-loop FSM probe bundle used in the co-simulation bench. It samples the current FSM state together with the loop's pre, start, end and quit state descriptors. From these it detects loop entry, iterations and loop exit, and emits one record per loop execution (trip count, cycle latency, completion flag) through a small FIFO with a valid/ready handshake. It also keeps sticky protocol-error flags for the bench scoreboard.

---
 rtl/seq_loop_monitor.sv | 237 +++++++++++++++++++++++
 tb/tb_seq_loop_monitor.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/seq_loop_monitor.sv
// seq_loop_monitor
// ----------------
// Watches the probe bundle of a sequential-loop FSM and produces one record
// per loop execution (trip count, latency in cycles, incomplete flag). Records
// are queued in a small FIFO and offered on a valid/ready port. Sticky error
// flags report illegal entries, unexpected exit targets, a finish while a loop
// is running, and records lost to a full FIFO.
//
// Ports
//   clock, reset            : rising-edge clock, async active-high reset
//   cur_state               : observed FSM state this cycle
//   pre_states_valid/pre_loop_state0/1 : legal predecessors of loop entry
//   iter_start_state        : first state of the loop body
//   iter_end_states_valid/iter_end_state0 : back-edge source state
//   loop_quit_state         : state from which the loop leaves
//   post_*/quit_*           : legal exit targets (used only to check exits)
//   one_state_loop          : loop body is a single state
//   one_state_block         : reserved, ignored
//   finish                  : observed design has completed
//   rec_valid/rec_ready     : record handshake
//   rec_trip/rec_latency/rec_incomplete : FIFO head record
//   active                  : monitor is tracking a loop
//   err_*                   : sticky error flags
//   drop_count              : saturating count of dropped records
//
// Handshake: the FIFO head is offered while rec_valid=1 and is held stable
// until an edge with rec_valid && rec_ready pops it; rec_ready while
// rec_valid=0 does nothing. Outputs come only from flops.

module seq_loop_monitor #(
    parameter int FSM_WIDTH  = 2,
    parameter int CNT_WIDTH  = 32,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [FSM_WIDTH-1:0] cur_state,
    input  logic [1:0]           pre_states_valid,
    input  logic [FSM_WIDTH-1:0] pre_loop_state0,
    input  logic [FSM_WIDTH-1:0] pre_loop_state1,
    input  logic [FSM_WIDTH-1:0] iter_start_state,
    input  logic                 iter_end_states_valid,
    input  logic [FSM_WIDTH-1:0] iter_end_state0,
    input  logic [FSM_WIDTH-1:0] loop_quit_state,
    input  logic                 post_states_valid,
    input  logic [FSM_WIDTH-1:0] post_loop_state0,
    input  logic                 quit_states_valid,
    input  logic [FSM_WIDTH-1:0] quit_loop_state0,
    input  logic                 one_state_loop,
    input  logic                 one_state_block,
    input  logic                 finish,
    output logic                 rec_valid,
    input  logic                 rec_ready,
    output logic [CNT_WIDTH-1:0] rec_trip,
    output logic [CNT_WIDTH-1:0] rec_latency,
    output logic                 rec_incomplete,
    output logic                 active,
    output logic                 err_bad_entry,
    output logic                 err_bad_exit,
    output logic                 err_finish_in_loop,
    output logic                 err_drop,
    output logic [7:0]           drop_count
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int REC_W = 2 * CNT_WIDTH + 1;

    typedef enum logic [1:0] {ST_IDLE, ST_IN_LOOP, ST_DONE} state_t;

    state_t                 state_q, state_d;
    logic [FSM_WIDTH-1:0]   prev_state_q, prev_state_d;
    logic                   first_cycle_q, first_cycle_d;
    logic [CNT_WIDTH-1:0]   trip_q, trip_d;
    logic [CNT_WIDTH-1:0]   lat_q, lat_d;
    logic                   err_bad_entry_q, err_bad_entry_d;
    logic                   err_bad_exit_q, err_bad_exit_d;
    logic                   err_finish_q, err_finish_d;
    logic                   err_drop_q, err_drop_d;
    logic [7:0]             drop_count_q, drop_count_d;
    logic [REC_W-1:0]       mem_q [FIFO_DEPTH];
    logic [REC_W-1:0]       mem_d [FIFO_DEPTH];
    logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]         count_q, count_d;

    logic                   prev_valid;
    logic                   pre_hit, back_edge, entry_hit, exit_hit;
    logic                   exit_checked, exit_ok;
    logic [CNT_WIDTH-1:0]   trip_inc, lat_inc;
    logic                   push, pop, full, do_write, drop;
    logic [REC_W-1:0]       push_rec;
    logic [REC_W-1:0]       head;

    // Reserved hint, intentionally not used by the monitor.
    logic unused_one_state_block;
    assign unused_one_state_block = one_state_block;

    always_comb begin
        // prev_state carries no information in the first cycle after reset.
        prev_valid = !first_cycle_q;
        pre_hit    = prev_valid &&
                     ((pre_states_valid[0] && prev_state_q == pre_loop_state0) ||
                      (pre_states_valid[1] && prev_state_q == pre_loop_state1));
        // A single-state loop iterates every cycle it stays in its state.
        back_edge  = prev_valid && cur_state == iter_start_state &&
                     ((iter_end_states_valid && prev_state_q == iter_end_state0) ||
                      (one_state_loop && prev_state_q == iter_start_state));
        entry_hit  = cur_state == iter_start_state &&
                     (!prev_valid || prev_state_q != iter_start_state);
        exit_hit   = prev_valid && prev_state_q == loop_quit_state &&
                     cur_state != iter_start_state;
        exit_checked = quit_states_valid || post_states_valid;
        exit_ok    = (quit_states_valid && cur_state == quit_loop_state0) ||
                     (post_states_valid && cur_state == post_loop_state0);
        trip_inc   = (trip_q == '1) ? trip_q : trip_q + CNT_WIDTH'(1);
        lat_inc    = (lat_q == '1) ? lat_q : lat_q + CNT_WIDTH'(1);

        state_d         = state_q;
        prev_state_d    = cur_state;
        first_cycle_d   = 1'b0;
        trip_d          = trip_q;
        lat_d           = lat_q;
        err_bad_entry_d = err_bad_entry_q;
        err_bad_exit_d  = err_bad_exit_q;
        err_finish_d    = err_finish_q;
        push            = 1'b0;
        push_rec        = '0;

        case (state_q)
            ST_IDLE: begin
                if (finish) begin
                    state_d = ST_DONE;
                end else if (entry_hit) begin
                    state_d = ST_IN_LOOP;
                    trip_d  = CNT_WIDTH'(1);
                    lat_d   = CNT_WIDTH'(1);
                    if (!pre_hit) err_bad_entry_d = 1'b1;
                end
            end
            ST_IN_LOOP: begin
                if (exit_hit) begin
                    // The exit cycle itself is not part of the latency, and an
                    // exit coinciding with finish still yields a complete record.
                    push     = 1'b1;
                    push_rec = {trip_q, lat_q, 1'b0};
                    state_d  = finish ? ST_DONE : ST_IDLE;
                    if (exit_checked && !exit_ok) err_bad_exit_d = 1'b1;
                end else begin
                    lat_d  = lat_inc;
                    trip_d = back_edge ? trip_inc : trip_q;
                    if (finish) begin
                        // The finish cycle is counted in the flushed record.
                        push         = 1'b1;
                        push_rec     = {trip_d, lat_d, 1'b1};
                        err_finish_d = 1'b1;
                        state_d      = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_DONE;
            end
            default: state_d = ST_IDLE;
        endcase

        // Record FIFO. When full, a push is accepted only if the head leaves
        // on the same edge; in that case the write lands in the slot being
        // freed, since wr_ptr equals rd_ptr when full.
        pop      = (count_q != '0) && rec_ready;
        full     = count_q == (PTR_W+1)'(FIFO_DEPTH);
        do_write = push && (!full || pop);
        drop     = push && full && !pop;

        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_write) begin
            mem_d[wr_ptr_q] = push_rec;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);
        if (do_write && !pop) count_d = count_q + (PTR_W+1)'(1);
        if (!do_write && pop) count_d = count_q - (PTR_W+1)'(1);

        err_drop_d   = err_drop_q || drop;
        drop_count_d = drop_count_q;
        if (drop && drop_count_q != 8'hFF) drop_count_d = drop_count_q + 8'd1;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q         <= ST_IDLE;
            prev_state_q    <= '0;
            first_cycle_q   <= 1'b1;
            trip_q          <= '0;
            lat_q           <= '0;
            err_bad_entry_q <= 1'b0;
            err_bad_exit_q  <= 1'b0;
            err_finish_q    <= 1'b0;
            err_drop_q      <= 1'b0;
            drop_count_q    <= '0;
            wr_ptr_q        <= '0;
            rd_ptr_q        <= '0;
            count_q         <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
        end else begin
            state_q         <= state_d;
            prev_state_q    <= prev_state_d;
            first_cycle_q   <= first_cycle_d;
            trip_q          <= trip_d;
            lat_q           <= lat_d;
            err_bad_entry_q <= err_bad_entry_d;
            err_bad_exit_q  <= err_bad_exit_d;
            err_finish_q    <= err_finish_d;
            err_drop_q      <= err_drop_d;
            drop_count_q    <= drop_count_d;
            wr_ptr_q        <= wr_ptr_d;
            rd_ptr_q        <= rd_ptr_d;
            count_q         <= count_d;
            for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= mem_d[i];
        end
    end

    assign head               = mem_q[rd_ptr_q];
    assign rec_valid          = count_q != '0;
    assign rec_trip           = head[REC_W-1 -: CNT_WIDTH];
    assign rec_latency        = head[CNT_WIDTH:1];
    assign rec_incomplete     = head[0];
    assign active             = state_q == ST_IN_LOOP;
    assign err_bad_entry      = err_bad_entry_q;
    assign err_bad_exit       = err_bad_exit_q;
    assign err_finish_in_loop = err_finish_q;
    assign err_drop           = err_drop_q;
    assign drop_count         = drop_count_q;

endmodule

// File: tb/tb_seq_loop_monitor.sv
// Directed bench for seq_loop_monitor with FSM_WIDTH=4, FIFO_DEPTH=4.
// Inputs change 1 time unit after the rising edge; outputs are sampled there.

module tb_seq_loop_monitor;

    localparam int FW = 4;
    localparam int CW = 32;
    localparam int FD = 4;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic [FW-1:0] cur_state = '0;
    logic [1:0]    pre_states_valid = 2'b01;
    logic [FW-1:0] pre_loop_state0 = 4'd1;
    logic [FW-1:0] pre_loop_state1 = 4'd0;
    logic [FW-1:0] iter_start_state = 4'd2;
    logic          iter_end_states_valid = 1'b1;
    logic [FW-1:0] iter_end_state0 = 4'd4;
    logic [FW-1:0] loop_quit_state = 4'd4;
    logic          post_states_valid = 1'b0;
    logic [FW-1:0] post_loop_state0 = 4'd0;
    logic          quit_states_valid = 1'b0;
    logic [FW-1:0] quit_loop_state0 = 4'd0;
    logic          one_state_loop = 1'b0;
    logic          one_state_block = 1'b0;
    logic          finish = 1'b0;
    logic          rec_valid;
    logic          rec_ready = 1'b0;
    logic [CW-1:0] rec_trip;
    logic [CW-1:0] rec_latency;
    logic          rec_incomplete;
    logic          active;
    logic          err_bad_entry, err_bad_exit, err_finish_in_loop, err_drop;
    logic [7:0]    drop_count;

    int checks = 0;
    int errors = 0;

    seq_loop_monitor #(.FSM_WIDTH(FW), .CNT_WIDTH(CW), .FIFO_DEPTH(FD)) dut (
        .clock(clock), .reset(reset), .cur_state(cur_state),
        .pre_states_valid(pre_states_valid), .pre_loop_state0(pre_loop_state0),
        .pre_loop_state1(pre_loop_state1), .iter_start_state(iter_start_state),
        .iter_end_states_valid(iter_end_states_valid), .iter_end_state0(iter_end_state0),
        .loop_quit_state(loop_quit_state), .post_states_valid(post_states_valid),
        .post_loop_state0(post_loop_state0), .quit_states_valid(quit_states_valid),
        .quit_loop_state0(quit_loop_state0), .one_state_loop(one_state_loop),
        .one_state_block(one_state_block), .finish(finish),
        .rec_valid(rec_valid), .rec_ready(rec_ready), .rec_trip(rec_trip),
        .rec_latency(rec_latency), .rec_incomplete(rec_incomplete), .active(active),
        .err_bad_entry(err_bad_entry), .err_bad_exit(err_bad_exit),
        .err_finish_in_loop(err_finish_in_loop), .err_drop(err_drop),
        .drop_count(drop_count)
    );

    // clock / reset
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // driver tasks
    task automatic step(input logic [FW-1:0] s);
        cur_state = s;
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        cur_state = '0;
        finish    = 1'b0;
        rec_ready = 1'b0;
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
        step(4'd0);
    endtask

    // Loop through start=2, body 3, end/quit=4, n iterations, then exit.
    task automatic run_loop(input int n, input logic [FW-1:0] exit_s);
        step(4'd1);
        for (int i = 0; i < n; i++) begin
            step(4'd2);
            step(4'd3);
            step(4'd4);
        end
        step(exit_s);
    endtask

    task automatic pop_one();
        rec_ready = 1'b1;
        step(4'd0);
        rec_ready = 1'b0;
    endtask

    task automatic check_rec(input string tag, input int trip, input int lat, input logic inc);
        check({tag, "_valid"}, 64'(rec_valid), 64'd1);
        check({tag, "_trip"}, 64'(rec_trip), 64'(trip));
        check({tag, "_lat"}, 64'(rec_latency), 64'(lat));
        check({tag, "_inc"}, 64'(rec_incomplete), 64'(inc));
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_valid"}, 64'(rec_valid), 64'd0);
        check({tag, "_trip"}, 64'(rec_trip), 64'd0);
        check({tag, "_lat"}, 64'(rec_latency), 64'd0);
        check({tag, "_inc"}, 64'(rec_incomplete), 64'd0);
        check({tag, "_active"}, 64'(active), 64'd0);
        check({tag, "_errs"}, 64'({err_bad_entry, err_bad_exit, err_finish_in_loop, err_drop}), 64'd0);
        check({tag, "_drops"}, 64'(drop_count), 64'd0);
    endtask

    initial begin
        // Reset state
        do_reset();
        check_idle_outputs("reset");

        // Basic loop: 1,2,3,4,2,3,4,5 -> trip 2, latency 6
        step(4'd1);
        step(4'd2);
        check("basic_active", 64'(active), 64'd1);
        step(4'd3); step(4'd4); step(4'd2); step(4'd3); step(4'd4);
        check("basic_no_early_rec", 64'(rec_valid), 64'd0);
        step(4'd5);
        check_rec("basic", 2, 6, 1'b0);
        check("basic_inactive", 64'(active), 64'd0);
        check("basic_errs", 64'({err_bad_entry, err_bad_exit, err_finish_in_loop, err_drop}), 64'd0);
        step(4'd0);
        check("basic_hold", 64'(rec_trip), 64'd2);
        pop_one();
        check("basic_popped", 64'(rec_valid), 64'd0);

        // Single-state loop: 1,3,3,3,3,6 -> trip 4, latency 4
        one_state_loop = 1'b1;
        iter_start_state = 4'd3; iter_end_state0 = 4'd3; loop_quit_state = 4'd3;
        step(4'd1); step(4'd3); step(4'd3); step(4'd3); step(4'd3); step(4'd6);
        check_rec("one_state", 4, 4, 1'b0);
        pop_one();
        one_state_loop = 1'b0;
        iter_start_state = 4'd2; iter_end_state0 = 4'd4; loop_quit_state = 4'd4;

        // Bad entry from 7 and exit to 6 while only 5 is a legal quit target
        quit_states_valid = 1'b1; quit_loop_state0 = 4'd5;
        step(4'd7); step(4'd2); step(4'd3); step(4'd4); step(4'd6);
        check_rec("bad", 1, 3, 1'b0);
        check("bad_entry", 64'(err_bad_entry), 64'd1);
        check("bad_exit", 64'(err_bad_exit), 64'd1);
        pop_one();
        quit_states_valid = 1'b0;

        // FIFO overflow: six loops with rec_ready low
        do_reset();
        for (int n = 1; n <= 6; n++) run_loop(n, 4'd5);
        check("ovf_drop_count", 64'(drop_count), 64'd2);
        check("ovf_err_drop", 64'(err_drop), 64'd1);
        rec_ready = 1'b1;
        for (int n = 1; n <= 4; n++) begin
            check_rec($sformatf("drain%0d", n), n, 3 * n, 1'b0);
            step(4'd0);
        end
        rec_ready = 1'b0;
        check("drain_empty", 64'(rec_valid), 64'd0);

        // Finish at loop cycle 3 -> incomplete record, latency 3
        do_reset();
        step(4'd1); step(4'd2); step(4'd3);
        finish = 1'b1;
        step(4'd4);
        finish = 1'b0;
        check_rec("fin", 1, 3, 1'b1);
        check("fin_err", 64'(err_finish_in_loop), 64'd1);
        check("fin_inactive", 64'(active), 64'd0);
        pop_one();
        run_loop(1, 4'd5);
        check("done_no_rec", 64'(rec_valid), 64'd0);
        check("done_inactive", 64'(active), 64'd0);

        // Exit and finish on the same edge: exit wins
        do_reset();
        step(4'd1); step(4'd2); step(4'd3); step(4'd4);
        finish = 1'b1;
        step(4'd5);
        finish = 1'b0;
        check_rec("exitfin", 1, 3, 1'b0);
        check("exitfin_err", 64'(err_finish_in_loop), 64'd0);
        check("exitfin_inactive", 64'(active), 64'd0);
        pop_one();
        run_loop(1, 4'd5);
        check("exitfin_done", 64'(rec_valid), 64'd0);

        // Asynchronous reset mid-loop and with a record pending
        do_reset();
        run_loop(1, 4'd5);
        step(4'd1); step(4'd2); step(4'd3);
        check("pre_rst_active", 64'(active), 64'd1);
        check("pre_rst_trip", 64'(rec_trip), 64'd1);
        reset = 1'b1;
        #1;
        check_idle_outputs("async_rst");
        @(posedge clock);
        #1 reset = 1'b0;
        step(4'd0);
        run_loop(2, 4'd5);
        check_rec("after_rst", 2, 6, 1'b0);
        check("after_rst_errs", 64'({err_bad_entry, err_bad_exit, err_finish_in_loop, err_drop}), 64'd0);

        // final report
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
